// File: rtl/seg7_pkg.sv
// Shared constants and the nibble-to-segment decode table for the
// seven-segment scan driver. Segment order is {a,b,c,d,e,f,g}, a = MSB.
// Define SEG7_HEX_EN to decode nibbles 10..15 as hex glyphs A b C d E F;
// otherwise those values render blank.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b000_0000;

`ifdef SEG7_HEX_EN
    localparam logic [6:0] SEG_HEX_A = 7'b111_0111;
    localparam logic [6:0] SEG_HEX_B = 7'b001_1111;
    localparam logic [6:0] SEG_HEX_C = 7'b100_1110;
    localparam logic [6:0] SEG_HEX_D = 7'b011_1101;
    localparam logic [6:0] SEG_HEX_E = 7'b100_1111;
    localparam logic [6:0] SEG_HEX_F = 7'b100_0111;
`else
    localparam logic [6:0] SEG_HEX_A = SEG_BLANK;
    localparam logic [6:0] SEG_HEX_B = SEG_BLANK;
    localparam logic [6:0] SEG_HEX_C = SEG_BLANK;
    localparam logic [6:0] SEG_HEX_D = SEG_BLANK;
    localparam logic [6:0] SEG_HEX_E = SEG_BLANK;
    localparam logic [6:0] SEG_HEX_F = SEG_BLANK;
`endif

    // Entry n is the pattern for nibble value n.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'b111_1110, 7'b011_0000, 7'b110_1101, 7'b111_1001,
        7'b011_0011, 7'b101_1011, 7'b101_1111, 7'b111_0000,
        7'b111_1111, 7'b111_1011,
        SEG_HEX_A, SEG_HEX_B, SEG_HEX_C, SEG_HEX_D, SEG_HEX_E, SEG_HEX_F
    };

    function automatic logic [6:0] seg7_lookup(input logic [3:0] nibble);
        return SEG_TABLE[nibble];
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational nibble-to-segment lookup. Hex glyphs for 10..15 are
// present only when SEG7_HEX_EN is defined (see seg7_pkg).
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = seg7_lookup(nibble);

endmodule

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed driver for a bank of NUM_DIGITS seven-segment digits.
// Each digit owns a slot of CLK_DIV cycles whose first GUARD cycles are dark
// to prevent ghosting. New data is shadowed in a pending register and only
// reaches the display register at a frame boundary, so a frame never tears.
// Optional hex glyphs for 10..15 are enabled by defining SEG7_HEX_EN.
module seg7_scan_mux
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 6,
    parameter int CLK_DIV    = 50000,
    parameter int GUARD      = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    input  logic                    blank_lz,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   dig_en,
    output logic                    frame_start,
    output logic                    pend
);

    localparam int DIG_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [DIG_W-1:0] DIG_LAST  = DIG_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]        slot_cnt;
    logic [DIG_W-1:0]        dig_idx;
    logic [4*NUM_DIGITS-1:0] disp_word;
    logic [4*NUM_DIGITS-1:0] pend_word;
    logic                    blank_q;

    logic                    slot_end;
    logic                    frame_end;
    logic                    in_guard;
    logic [NUM_DIGITS-1:0]   lz_mask;
    logic                    zero_run;
    logic [3:0]              cur_nib;
    logic                    cur_blank;
    logic [6:0]              cur_seg;

    assign slot_end  = (slot_cnt == SLOT_LAST);
    assign frame_end = slot_end && (dig_idx == DIG_LAST);
    assign in_guard  = (slot_cnt < CNT_W'(GUARD));

    // Leading-zero mask: digit i>0 is a leading zero when it and every higher digit are 0.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        lz_mask  = '0;
        zero_run = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_run   = zero_run && (disp_word[4*i +: 4] == 4'h0);
            lz_mask[i] = zero_run;
        end
    end

    // Select the nibble and blanking state of the digit currently being scanned.
    always_comb begin
        cur_nib   = 4'h0;
        cur_blank = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (dig_idx == DIG_W'(i)) begin
                cur_nib   = disp_word[4*i +: 4];
                cur_blank = blank_q && lz_mask[i];
            end
        end
    end

    seg7_decode u_decode (
        .nibble (cur_nib),
        .seg    (cur_seg)
    );

    // Slot and digit counters; blank_lz is re-sampled at each slot edge.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            slot_cnt <= '0;
            dig_idx  <= '0;
            blank_q  <= 1'b0;
        end else if (slot_end) begin
            slot_cnt <= '0;
            dig_idx  <= (dig_idx == DIG_LAST) ? '0 : dig_idx + 1'b1;
            blank_q  <= blank_lz;
        end else begin
            slot_cnt <= slot_cnt + 1'b1;
        end
    end

    // Pending/display shadowing; a load on the boundary cycle bypasses the pending stage.
    always_ff @(posedge clk) begin
        // NOTE: the data registers are reset too, so a reset always shows a clean "0" frame.
        if (!rst_n) begin
            disp_word <= '0;
            pend_word <= '0;
            pend      <= 1'b0;
        end else if (load && frame_end) begin
            disp_word <= data_in;
            pend      <= 1'b0;
        end else if (load) begin
            pend_word <= data_in;
            pend      <= 1'b1;
        end else if (frame_end && pend) begin
            disp_word <= pend_word;
            pend      <= 1'b0;
        end
    end

    // Registered display outputs, one cycle behind the counter state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg         <= SEG_BLANK;
            dig_en      <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= (slot_cnt == '0) && (dig_idx == '0);
            if (in_guard || cur_blank) begin
                seg    <= SEG_BLANK;
                dig_en <= '0;
            end else begin
                seg    <= cur_seg;
                dig_en <= NUM_DIGITS'(1) << dig_idx;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Directed self-checking bench for seg7_scan_mux (NUM_DIGITS=4, CLK_DIV=4,
// GUARD=1). Expected patterns for 10..15 follow SEG7_HEX_EN when defined.
module tb_seg7_scan_mux;

    localparam int N   = 4;
    localparam int DIV = 4;
    localparam int GRD = 1;

    localparam logic [6:0] S0 = 7'b111_1110;
    localparam logic [6:0] S1 = 7'b011_0000;
    localparam logic [6:0] S2 = 7'b110_1101;
    localparam logic [6:0] S3 = 7'b111_1001;
    localparam logic [6:0] S4 = 7'b011_0011;
    localparam logic [6:0] S5 = 7'b101_1011;
    localparam logic [6:0] S6 = 7'b101_1111;
    localparam logic [6:0] S7 = 7'b111_0000;
    localparam logic [6:0] S8 = 7'b111_1111;
    localparam logic [6:0] S9 = 7'b111_1011;
`ifdef SEG7_HEX_EN
    localparam logic [6:0] SA = 7'b111_0111;
    localparam logic [6:0] SF = 7'b100_0111;
`else
    localparam logic [6:0] SA = 7'b000_0000;
    localparam logic [6:0] SF = 7'b000_0000;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          load;
    logic [4*N-1:0] data_in;
    logic          blank_lz;
    logic [6:0]    seg;
    logic [N-1:0]  dig_en;
    logic          frame_start;
    logic          pend;

    int tests_run    = 0;
    int tests_failed = 0;

    seg7_scan_mux #(
        .NUM_DIGITS (N),
        .CLK_DIV    (DIV),
        .GUARD      (GRD)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (load),
        .data_in     (data_in),
        .blank_lz    (blank_lz),
        .seg         (seg),
        .dig_en      (dig_en),
        .frame_start (frame_start),
        .pend        (pend)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Run one full 16-cycle frame starting at counter state 0 and check every cycle.
    // es packs the expected pattern of digit i at [7*i +: 7]; en marks digits that light.
    // la/lb are in-frame cycle indices at which a load is applied (-1 = none).
    task automatic check_frame(input string tag, input logic [27:0] es, input logic [3:0] en,
                               input int la, input logic [15:0] va,
                               input int lb, input logic [15:0] vb);
        for (int j = 0; j < DIV * N; j++) begin
            int          slot;
            int          cnt;
            logic        lit;
            logic        exp_pend;
            logic [3:0]  exp_den;
            logic [6:0]  exp_seg;
            if (j == la) begin
                load    = 1'b1;
                data_in = va;
            end else if (j == lb) begin
                load    = 1'b1;
                data_in = vb;
            end
            step();
            load = 1'b0;
            slot     = j / DIV;
            cnt      = j % DIV;
            lit      = (cnt >= GRD) && en[slot];
            exp_den  = lit ? (4'b0001 << slot) : 4'b0000;
            exp_seg  = lit ? es[7*slot +: 7] : 7'b000_0000;
            exp_pend = (j < DIV * N - 1) &&
                       ((la >= 0 && la < DIV * N - 1 && j >= la) ||
                        (lb >= 0 && lb < DIV * N - 1 && j >= lb));
            check($sformatf("%s c%0d seg", tag, j), 32'(seg), 32'(exp_seg));
            check($sformatf("%s c%0d dig_en", tag, j), 32'(dig_en), 32'(exp_den));
            check($sformatf("%s c%0d frame_start", tag, j), 32'(frame_start), 32'(j == 0));
            check($sformatf("%s c%0d pend", tag, j), 32'(pend), 32'(exp_pend));
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        load     = 1'b0;
        data_in  = '0;
        blank_lz = 1'b0;

        // Reset: all outputs low.
        for (int k = 0; k < 2; k++) begin
            step();
            check("rst seg", 32'(seg), 32'h0);
            check("rst dig_en", 32'(dig_en), 32'h0);
            check("rst frame_start", 32'(frame_start), 32'h0);
            check("rst pend", 32'(pend), 32'h0);
        end
        rst_n = 1'b1;

        // Cleared display shows "0" on every digit with blanking off.
        check_frame("zero", {S0, S0, S0, S0}, 4'b1111, -1, 16'h0, -1, 16'h0);
        // Mid-frame load: pend rises, display unchanged until the boundary.
        check_frame("pend4321", {S0, S0, S0, S0}, 4'b1111, 5, 16'h4321, -1, 16'h0);
        // 4321 appears; blanking enabled and 0050 queued.
        blank_lz = 1'b1;
        check_frame("show4321", {S4, S3, S2, S1}, 4'b1111, 2, 16'h0050, -1, 16'h0);
        // 0050 with leading-zero blanking: digits 2 and 3 dark.
        check_frame("lz0050", {S0, S0, S5, S0}, 4'b0011, 7, 16'h0000, -1, 16'h0);
        // All-zero word: only digit 0 lit; load on the boundary cycle bypasses pending.
        check_frame("lz0000", {S0, S0, S0, S0}, 4'b0001, 15, 16'h9876, -1, 16'h0);
        // 9876 shown directly; two loads before the boundary, the last one wins.
        check_frame("show9876", {S9, S8, S7, S6}, 4'b1111, 3, 16'h1111, 9, 16'hFA00);
        // FA00: higher digits non-zero, so inner zeros are not blanked.
        check_frame("hexFA00", {SF, SA, S0, S0}, 4'b1111, -1, 16'h0, -1, 16'h0);

        // Queue a value, then reset in the middle of digit 2's slot.
        load    = 1'b1;
        data_in = 16'h0003;
        step();
        load = 1'b0;
        check("pre_rst pend", 32'(pend), 32'h1);
        check("pre_rst frame_start", 32'(frame_start), 32'h1);
        for (int k = 1; k < 9; k++) step();
        step();
        check("pre_rst dig_en", 32'(dig_en), 32'h4);
        check("pre_rst seg", 32'(seg), 32'(SA));
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("mid_rst seg", 32'(seg), 32'h0);
        check("mid_rst dig_en", 32'(dig_en), 32'h0);
        check("mid_rst frame_start", 32'(frame_start), 32'h0);
        check("mid_rst pend", 32'(pend), 32'h0);
        // Restart at digit 0 with cleared display; the queued value must be gone.
        check_frame("post_rst", {S0, S0, S0, S0}, 4'b0001, -1, 16'h0, -1, 16'h0);
        check_frame("post_rst2", {S0, S0, S0, S0}, 4'b0001, -1, 16'h0, -1, 16'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
